// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO and runs mult/div as fixed-latency ops.
// The result is computed when the op starts and held in pending registers until the last busy cycle.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_ans
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_we_q, pend_we_d;

   logic [63:0] mul_a, mul_b, prod;
   logic        div_sgn, neg_a, neg_b;
   logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;

   // Datapath: signed division is done on magnitudes so that
   // 0x80000000 / -1 wraps to 0x80000000 without any special case.
   always_comb begin
      mul_a   = (mdu_op == OP_MULT) ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
      mul_b   = (mdu_op == OP_MULT) ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
      prod    = mul_a * mul_b;
      div_sgn = (mdu_op == OP_DIV);
      neg_a   = div_sgn & rs_val[31];
      neg_b   = div_sgn & rt_val[31];
      ua      = neg_a ? (~rs_val + 32'd1) : rs_val;
      ub      = neg_b ? (~rt_val + 32'd1) : rt_val;
      ub_safe = (ub == 32'd0) ? 32'd1 : ub;
      uq      = ua / ub_safe;
      ur      = ua % ub_safe;
      quo     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      rem     = neg_a ? (~ur + 32'd1) : ur;
   end

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1) && pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (start) begin
         case (mdu_op)
            OP_MULT, OP_MULTU: begin
               {pend_hi_d, pend_lo_d} = prod;
               pend_we_d = 1'b1;
               cnt_d     = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
               pend_hi_d = rem;
               pend_lo_d = quo;
               // divide by zero still burns the busy cycles but leaves HI/LO alone
               pend_we_d = (rt_val != 32'd0);
               cnt_d     = CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_we_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
      end
   end

   always_comb begin
      case (mdu_op)
         OP_MFHI: mdu_ans = hi_q;
         OP_MFLO: mdu_ans = lo_q;
         default: mdu_ans = 32'd0;
      endcase
   end

   assign busy = (cnt_q != '0);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: table of mult/div vectors plus hand sequences for
// move-to/from, divide by zero, no-op codes and reset mid-operation.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  mdu_op;
   logic [31:0] rs_val, rt_val;
   logic        busy;
   logic [31:0] hi, lo, mdu_ans;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
      .hi(hi), .lo(lo), .mdu_ans(mdu_ans)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          n;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t        vecs[6];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] m_hi, m_lo;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Issue one multi-cycle op and check busy window, late write-back, final HI/LO.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] eh, input logic [31:0] el);
      @(negedge clk);
      start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      for (int i = 1; i <= n; i++) begin
         chk($sformatf("busy op%0d c%0d", op, i), {31'd0, busy}, 32'd1);
         if (i == n) begin
            chk($sformatf("hi_old op%0d", op), hi, m_hi);
            chk($sformatf("lo_old op%0d", op), lo, m_lo);
         end
         @(negedge clk);
      end
      chk($sformatf("busy_done op%0d", op), {31'd0, busy}, 32'd0);
      chk($sformatf("hi op%0d", op), hi, eh);
      chk($sformatf("lo op%0d", op), lo, el);
      m_hi = eh; m_lo = el;
   endtask

   initial begin
      vecs[0] = '{4'd1, 32'h00000003, 32'hFFFFFFFC, 5,  32'hFFFFFFFF, 32'hFFFFFFF4};
      vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{4'd4, 32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC};
      vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vecs[5] = '{4'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};

      reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = '0; rt_val = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_ans", mdu_ans, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;

      foreach (vecs[k]) run_op(vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].n, vecs[k].eh, vecs[k].el);

      // mthi then mflo/mfhi read-back; mtlo then mflo
      @(negedge clk);
      start = 1'b1; mdu_op = 4'd5; rs_val = 32'h0000ABCD;
      @(negedge clk);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      mdu_op = 4'd8; #1;
      chk("mflo_ans", mdu_ans, m_lo);
      @(negedge clk);
      mdu_op = 4'd7; #1;
      chk("mfhi_ans", mdu_ans, 32'h0000ABCD);
      chk("mfhi_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      mdu_op = 4'd6; rs_val = 32'd7;
      @(negedge clk);
      mdu_op = 4'd8; #1;
      chk("mtlo_ans", mdu_ans, 32'd7);
      chk("mtlo_hi", hi, 32'h0000ABCD);
      mdu_op = 4'd1; #1;
      chk("ans_other", mdu_ans, 32'd0);
      start = 1'b0; mdu_op = 4'd0;
      m_hi = 32'h0000ABCD; m_lo = 32'd7;

      // divide by zero keeps HI/LO after a full busy window
      @(negedge clk);
      start = 1'b1; mdu_op = 4'd5; rs_val = 32'h11;
      @(negedge clk);
      mdu_op = 4'd6; rs_val = 32'h22;
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      m_hi = 32'h11; m_lo = 32'h22;
      run_op(4'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);

      // undefined op code is a no-op
      @(negedge clk);
      start = 1'b1; mdu_op = 4'd9; rs_val = 32'h55; rt_val = 32'h3;
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      chk("op9_busy", {31'd0, busy}, 32'd0);
      chk("op9_hi", hi, 32'h11);
      chk("op9_lo", lo, 32'h22);

      // reset mid-divide, with an ignored start while busy
      @(negedge clk);
      start = 1'b1; mdu_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      chk("abort_busy1", {31'd0, busy}, 32'd1);
      mdu_op = 4'd1; rs_val = 32'd3; rt_val = 32'd5;
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      chk("abort_busy2", {31'd0, busy}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 4; c <= 12; c++) begin
         chk($sformatf("abort_busy T+%0d", c), {31'd0, busy}, 32'd0);
         chk($sformatf("abort_hi T+%0d", c), hi, 32'd0);
         chk($sformatf("abort_lo T+%0d", c), lo, 32'd0);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
